// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS core front end: nop encoding, default
// reset vector and the fetch FSM state encodings.
package cpu_defs;

   localparam logic [31:0] NOP_INST     = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: rst > bubble > hold > load.
// A bubble still records the fetch PC so the squashed slot keeps a
// meaningful id_pc / id_pc4.
module if_id_reg
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   input  logic [31:0] pc4,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   // Register update with reset, squash, hold and normal load.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_inst  <= NOP_INST;
         id_pc    <= 32'h0;
         id_pc4   <= 32'h0;
      end else if (bubble) begin
         id_valid <= 1'b0;
         id_inst  <= NOP_INST;
         id_pc    <= pc;
         id_pc4   <= pc4;
      end else if (hold) begin
         id_valid <= id_valid;
         id_inst  <= id_inst;
         id_pc    <= id_pc;
         id_pc4   <= id_pc4;
      end else if (load) begin
         id_valid <= 1'b1;
         id_inst  <= inst;
         id_pc    <= pc;
         id_pc4   <= pc4;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, boot/run/stall
// FSM and the IF/ID register feeding decode.
// Build option: IF_DELAY_SLOT_EN keeps the word fetched alongside a taken
// redirect (MIPS branch delay slot) instead of squashing it.
module if_fetch
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          IM_AW    = 10
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] im_addr,
   input  logic [31:0] im_inst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   // The memory indexes pc[IM_AW+1:2]; the address must fit in 32 bits.
   if (IM_AW < 1 || IM_AW > 30) begin : g_aw_check
      $error("if_fetch: IM_AW out of range");
   end

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        stall_eff;
   logic        hold;
   logic        bubble;

   assign im_addr  = pc;
   assign pc_plus4 = pc + 32'd4;

   // The boot fetch always proceeds: nothing is in decode yet to hazard on.
   assign stall_eff = stall_i && (state != S_BOOT);

   // A redirect overrides a stall; the squash is dropped in delay-slot builds.
   assign hold = stall_eff && !redirect_i;
`ifdef IF_DELAY_SLOT_EN
   assign bubble = 1'b0;
`else
   assign bubble = redirect_i;
`endif

   // Next-PC select: redirect target (word aligned), hold, or sequential.
   always_comb begin
      pc_next = pc_plus4;
      if (redirect_i)
         pc_next = redirect_pc_i & ~32'h3;
      else if (stall_eff)
         pc_next = pc;
   end

   // Fetch FSM transitions.
   always_comb begin
      state_next = S_RUN;
      case (state)
         S_BOOT:  state_next = S_RUN;
         S_RUN,
         S_STALL: state_next = hold ? S_STALL : S_RUN;
         default: state_next = S_RUN;
      endcase
   end

   // PC and FSM state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= S_BOOT;
      end else begin
         pc    <= pc_next;
         state <= state_next;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b1),
      .hold     (hold),
      .bubble   (bubble),
      .inst     (im_inst),
      .pc       (pc),
      .pc4      (pc_plus4),
      .id_valid (id_valid),
      .id_inst  (id_inst),
      .id_pc    (id_pc),
      .id_pc4   (id_pc4)
   );

endmodule
